// File: rtl/psg_bus_pkg.sv
// rtl/psg_bus_pkg.sv - shared bus codes, FSM states and command layout for the PSG bus master
package psg_bus_pkg;

    // {bdir, bc2, bc1} function codes on the PSG register port
    localparam logic [2:0] PSG_INACT = 3'b010;
    localparam logic [2:0] PSG_LATCH = 3'b111;
    localparam logic [2:0] PSG_WRITE = 3'b110;
    localparam logic [2:0] PSG_READ  = 3'b011;

    localparam int CMD_W = 17;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_GAP,
        ST_XFER,
        ST_XFER_GAP
    } state_t;

    typedef struct packed {
        logic       rd;
        logic [7:0] addr;
        logic [7:0] data;
    } cmd_t;

endpackage

// File: rtl/psg_cmd_fifo.sv
// rtl/psg_cmd_fifo.sv - synchronous command FIFO with flop-held head entry
module psg_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // push is refused while full even if a pop frees a slot this cycle
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/psg_bus_master.sv
// rtl/psg_bus_master.sv - queued register read/write initiator for the AY-3-8912 PSG bus
module psg_bus_master
    import psg_bus_pkg::*;
#(
    parameter int HOLD_CYCLES = 2,
    parameter int GAP_CYCLES  = 1,
    parameter int FIFO_DEPTH  = 4,
    parameter int ADDR_CACHE  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rd,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       psg_a8,
    output logic       psg_bdir,
    output logic       psg_bc2,
    output logic       psg_bc1,
    output logic [7:0] psg_dout,
    input  logic [7:0] psg_din,
    input  logic       psg_oe_n
);

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);
    localparam logic [3:0] GAP_LAST  = 4'(GAP_CYCLES - 1);

    state_t     state, state_next;
    logic [3:0] cnt, cnt_next;
    cmd_t       head, cur, src;
    logic       fifo_full, fifo_empty, fifo_pop;
    logic       cache_valid, cache_set, cache_hit;
    logic [7:0] cache_addr;
    logic       capture, rsp_valid_next;
    logic [2:0] code, code_next;
    logic       a8_next;
    logic [7:0] dout_next;

    psg_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (cmd_valid),
        .push_data ({cmd_rd, cmd_addr, cmd_data}),
        .pop       (fifo_pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign cmd_ready = ~fifo_full;
    assign busy      = ~fifo_empty | (state != ST_IDLE);
    assign cache_hit = (ADDR_CACHE != 0) && cache_valid && (cache_addr == head.addr);
    assign {psg_bdir, psg_bc2, psg_bc1} = code;

    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        fifo_pop       = 1'b0;
        cache_set      = 1'b0;
        capture        = 1'b0;
        rsp_valid_next = 1'b0;
        // the popped command is not in cur until the next edge, so IDLE drives from head
        src            = (state == ST_IDLE) ? head : cur;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    cnt_next   = HOLD_LAST;
                    state_next = cache_hit ? ST_XFER : ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (cnt == 4'd0) begin
                    state_next = ST_ADDR_GAP;
                    cnt_next   = GAP_LAST;
                    cache_set  = 1'b1;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            ST_ADDR_GAP: begin
                if (cnt == 4'd0) begin
                    state_next = ST_XFER;
                    cnt_next   = HOLD_LAST;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            ST_XFER: begin
                if (cnt == 4'd0) begin
                    state_next     = ST_XFER_GAP;
                    cnt_next       = GAP_LAST;
                    capture        = cur.rd;
                    rsp_valid_next = cur.rd;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            ST_XFER_GAP: begin
                if (cnt == 4'd0) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        code_next = PSG_INACT;
        a8_next   = 1'b0;
        dout_next = 8'hFF;
        case (state_next)
            ST_ADDR: begin
                code_next = PSG_LATCH;
                a8_next   = 1'b1;
                dout_next = src.addr;
            end
            ST_XFER: begin
                code_next = src.rd ? PSG_READ : PSG_WRITE;
                a8_next   = 1'b1;
                dout_next = src.rd ? 8'hFF : src.data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= 4'd0;
            cur         <= '0;
            cache_valid <= 1'b0;
            cache_addr  <= 8'h00;
            rsp_valid   <= 1'b0;
            rsp_data    <= 8'hFF;
            code        <= PSG_INACT;
            psg_a8      <= 1'b0;
            psg_dout    <= 8'hFF;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            rsp_valid <= rsp_valid_next;
            code      <= code_next;
            psg_a8    <= a8_next;
            psg_dout  <= dout_next;
            if (fifo_pop) begin
                cur <= head;
            end
            if (cache_set) begin
                cache_valid <= 1'b1;
                cache_addr  <= cur.addr;
            end
            if (capture) begin
                rsp_data <= psg_oe_n ? 8'hFF : psg_din;
            end
        end
    end

endmodule
